// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Decode-stage data-hazard and forwarding unit. A shift register of
// FWD_DEPTH entries mirrors the destination of every in-flight instruction
// downstream of decode. Each decode source operand is resolved against the
// youngest matching producer; a load whose data is not yet available stalls
// fetch/decode and a bubble is pushed instead. Stall cycles are counted with
// a saturating counter.

module hazard_forward_unit #(
  parameter int XLEN          = 32,
  parameter int REGISTER_SIZE = 5,
  parameter int NUM_SRC       = 2,
  parameter int FWD_DEPTH     = 2,
  parameter int LOAD_LATENCY  = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,           // asynchronous, active-low
  input  logic                                     dec_valid,
  input  logic                                     dec_flush,
  input  logic [REGISTER_SIZE-1:0]                 dec_dest,
  input  logic                                     dec_reg_write,
  input  logic                                     dec_is_load,
  input  logic [NUM_SRC*REGISTER_SIZE-1:0]         dec_src,
  input  logic [NUM_SRC-1:0]                       dec_src_used,
  input  logic [NUM_SRC*XLEN-1:0]                  dec_operand,
  input  logic [FWD_DEPTH*XLEN-1:0]                stage_data,
  output logic [NUM_SRC*XLEN-1:0]                  fwd_operand,
  output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]   fwd_sel,
  output logic                                     f_to_d_enable_ff,
  output logic                                     d_to_e_enable_ff,
  output logic [CNT_WIDTH-1:0]                     stall_count
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // In-flight tracker, index k = pipeline stage k (1 = execute).
  logic                     valid_r     [1:FWD_DEPTH];
  logic [REGISTER_SIZE-1:0] dest_r      [1:FWD_DEPTH];
  logic                     reg_write_r [1:FWD_DEPTH];
  logic                     is_load_r   [1:FWD_DEPTH];
  logic [CNT_WIDTH-1:0]     stall_count_r;

  // Per-slot resolution results.
  logic [NUM_SRC-1:0]       hazard_s;
  logic [SEL_W-1:0]         safe_sel_s  [NUM_SRC];
  logic                     stall_s;
  logic                     push_s;

  // A tracked producer supplies a source only for a real, nonzero read of a
  // register it actually writes; x0 never matches.
  function automatic logic src_hit(
    input logic                     valid_in,
    input logic                     used_in,
    input logic [REGISTER_SIZE-1:0] src_in,
    input logic                     entry_valid,
    input logic                     entry_rw,
    input logic [REGISTER_SIZE-1:0] entry_dest
  );
    src_hit = valid_in && used_in && (src_in != {REGISTER_SIZE{1'b0}}) &&
              entry_valid && entry_rw && (entry_dest == src_in);
  endfunction

  // Find the youngest producer per slot (hazard) and the youngest producer whose data is usable (forward select).
  always_comb begin
    hazard_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      safe_sel_s[i] = {SEL_W{1'b0}};
      // Walk oldest to youngest so the youngest match is the last one written.
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (src_hit(dec_valid, dec_src_used[i], dec_src[i*REGISTER_SIZE +: REGISTER_SIZE],
                    valid_r[k], reg_write_r[k], dest_r[k])) begin
          hazard_s[i] = is_load_r[k] && (k <= LOAD_LATENCY);
          if (!(is_load_r[k] && (k <= LOAD_LATENCY))) begin
            safe_sel_s[i] = SEL_W'(k);
          end else begin
            safe_sel_s[i] = safe_sel_s[i];
          end
        end else begin
          hazard_s[i] = hazard_s[i];
        end
      end
    end
  end

  // Squashing the decode instruction removes the need to wait for its operands.
  always_comb begin
    stall_s          = (|hazard_s) && !dec_flush;
    push_s           = dec_valid && !dec_flush && !stall_s;
    f_to_d_enable_ff = !stall_s;
    d_to_e_enable_ff = !stall_s;
  end

  // Operand mux: register-file value unless a tracked stage was selected.
  always_comb begin
    fwd_operand = dec_operand;
    fwd_sel     = {(NUM_SRC*SEL_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = safe_sel_s[i];
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        if (safe_sel_s[i] == SEL_W'(k)) begin
          fwd_operand[i*XLEN +: XLEN] = stage_data[(k-1)*XLEN +: XLEN];
        end else begin
          fwd_operand[i*XLEN +: XLEN] = fwd_operand[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Advance the tracker one stage; stalls, flushes and idle decode insert a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        valid_r[k]     <= 1'b0;
        dest_r[k]      <= {REGISTER_SIZE{1'b0}};
        reg_write_r[k] <= 1'b0;
        is_load_r[k]   <= 1'b0;
      end
    end else begin
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        valid_r[k]     <= valid_r[k-1];
        dest_r[k]      <= dest_r[k-1];
        reg_write_r[k] <= reg_write_r[k-1];
        is_load_r[k]   <= is_load_r[k-1];
      end
      if (push_s) begin
        valid_r[1]     <= 1'b1;
        dest_r[1]      <= dec_dest;
        reg_write_r[1] <= dec_reg_write;
        is_load_r[1]   <= dec_is_load;
      end else begin
        valid_r[1]     <= 1'b0;
        dest_r[1]      <= {REGISTER_SIZE{1'b0}};
        reg_write_r[1] <= 1'b0;
        is_load_r[1]   <= 1'b0;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_r <= {CNT_WIDTH{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. Three instances share the decode
// stimulus: A uses the default configuration, B has FWD_DEPTH=3 and
// LOAD_LATENCY=2, C has a 2-bit stall counter. Each scenario starts from
// reset and checks only the instance it targets.

module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_flush, dec_reg_write, dec_is_load;
  logic [4:0]  dec_dest;
  logic [9:0]  dec_src;
  logic [1:0]  dec_src_used;
  logic [63:0] dec_operand;
  logic [63:0] sd_a;
  logic [95:0] sd_b;

  logic [63:0] op_a, op_b, op_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic        f2d_a, d2e_a, f2d_b, d2e_b, f2d_c, d2e_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit u_dut_a (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_flush(dec_flush),
    .dec_dest(dec_dest), .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .dec_src(dec_src), .dec_src_used(dec_src_used), .dec_operand(dec_operand),
    .stage_data(sd_a), .fwd_operand(op_a), .fwd_sel(sel_a),
    .f_to_d_enable_ff(f2d_a), .d_to_e_enable_ff(d2e_a), .stall_count(cnt_a)
  );

  hazard_forward_unit #(.FWD_DEPTH(3), .LOAD_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_flush(dec_flush),
    .dec_dest(dec_dest), .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .dec_src(dec_src), .dec_src_used(dec_src_used), .dec_operand(dec_operand),
    .stage_data(sd_b), .fwd_operand(op_b), .fwd_sel(sel_b),
    .f_to_d_enable_ff(f2d_b), .d_to_e_enable_ff(d2e_b), .stall_count(cnt_b)
  );

  hazard_forward_unit #(.CNT_WIDTH(2)) u_dut_c (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_flush(dec_flush),
    .dec_dest(dec_dest), .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .dec_src(dec_src), .dec_src_used(dec_src_used), .dec_operand(dec_operand),
    .stage_data(sd_a), .fwd_operand(op_c), .fwd_sel(sel_c),
    .f_to_d_enable_ff(f2d_c), .d_to_e_enable_ff(d2e_c), .stall_count(cnt_c)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic [4:0] d, input logic rw,
                       input logic ld, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] used);
    dec_valid     = v;
    dec_flush     = fl;
    dec_dest      = d;
    dec_reg_write = rw;
    dec_is_load   = ld;
    dec_src       = {s1, s0};
    dec_src_used  = used;
    #1;
  endtask

  task automatic pulse_reset;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    dec_operand = {32'hBBBB_0001, 32'hAAAA_0000};
    sd_a        = {32'hDEAD_0000, 32'h0000_1234};
    sd_b        = {32'hCAFE_F00D, 32'h0000_2222, 32'h0000_3333};
    // Reset: empty tracker, a valid reader of x5 still sees the register file.
    drive(1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11);
    check_value("rst_f2d", {63'd0, f2d_a}, 64'd1);
    check_value("rst_d2e", {63'd0, d2e_a}, 64'd1);
    check_value("rst_sel", {60'd0, sel_a}, 64'd0);
    check_value("rst_op", op_a, 64'hBBBB0001_AAAA0000);
    check_value("rst_cnt", {48'd0, cnt_a}, 64'd0);
    check_value("rst_c_en", {62'd0, f2d_c, d2e_c}, 64'd3);
    check_value("rst_c_sel_op", {sel_c, op_c[59:0]}, {4'h0, 60'hBBB0001_AAAA0000});
    check_value("rst_b_d2e", {63'd0, d2e_b}, 64'd1);
    tick;

    // Back-to-back ALU dependency forwards from stage 1.
    pulse_reset;
    drive(1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11);
    check_value("alu_sel", {60'd0, sel_a}, 64'h5);
    check_value("alu_op", op_a, 64'h00001234_00001234);
    check_value("alu_f2d", {63'd0, f2d_a}, 64'd1);
    tick;

    // Load-use: A stalls once, B stalls twice.
    pulse_reset;
    sd_a = {32'hCAFE_F00D, 32'h0000_1111};
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd1, 5'd7, 2'b11);
    check_value("lu_a_f2d", {63'd0, f2d_a}, 64'd0);
    check_value("lu_a_d2e", {63'd0, d2e_a}, 64'd0);
    check_value("lu_a_sel1", {62'd0, sel_a[3:2]}, 64'd0);
    check_value("lu_b_d2e0", {63'd0, d2e_b}, 64'd0);
    tick;
    check_value("lu_a_cnt", {48'd0, cnt_a}, 64'd1);
    check_value("lu_a_f2d_go", {63'd0, f2d_a}, 64'd1);
    check_value("lu_a_sel", {60'd0, sel_a}, 64'h2);
    check_value("lu_a_op", op_a, 64'hBBBB0001_CAFEF00D);
    check_value("lu_b_d2e1", {63'd0, d2e_b}, 64'd0);
    tick;
    check_value("lu_b_f2d_go", {63'd0, f2d_b}, 64'd1);
    check_value("lu_b_sel", {60'd0, sel_b}, 64'h3);
    check_value("lu_b_op", op_b, 64'hBBBB0001_CAFEF00D);
    check_value("lu_b_cnt", {48'd0, cnt_b}, 64'd2);
    tick;

    // x0 producer and a non-writing producer are never forwarded.
    pulse_reset;
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
    check_value("x0_sel", {60'd0, sel_a}, 64'h0);
    check_value("x0_op", op_a, 64'hBBBB0001_CAFEF00D & 64'hFFFFFFFF_00000000 | 64'h00000000_AAAA0000);
    tick;
    drive(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'd3, 5'd3, 2'b01);
    check_value("store_sel", {60'd0, sel_a}, 64'h0);
    check_value("store_f2d", {63'd0, f2d_a}, 64'd1);
    tick;

    // Two producers of x9: the younger one wins.
    pulse_reset;
    sd_a = {32'h9999_0002, 32'h9999_0001};
    drive(1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 5'd9, 5'd9, 2'b11);
    check_value("young_sel", {60'd0, sel_a}, 64'h5);
    check_value("young_op", op_a, 64'h99990001_99990001);
    tick;

    // Flush on a load-use hazard: no stall, and the squashed x7 writer leaves a bubble.
    pulse_reset;
    sd_a = {32'hCAFE_F00D, 32'h0000_1111};
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01);
    check_value("flush_f2d", {63'd0, f2d_a}, 64'd1);
    check_value("flush_d2e", {63'd0, d2e_a}, 64'd1);
    tick;
    drive(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01);
    check_value("flush_bubble_sel", {60'd0, sel_a}, 64'h2);
    check_value("flush_bubble_op", op_a, 64'hBBBB0001_CAFEF00D);
    check_value("flush_cnt", {48'd0, cnt_a}, 64'd0);
    tick;

    // Reset asserted during a stall.
    pulse_reset;
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick;
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd7, 2'b01);
    tick;
    tick;
    drive(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01);
    check_value("mid_f2d_stall", {63'd0, f2d_a}, 64'd0);
    check_value("mid_cnt_pre", {48'd0, cnt_a}, 64'd1);
    rst = 1'b0;
    #1;
    check_value("mid_f2d_rst", {63'd0, f2d_a}, 64'd1);
    check_value("mid_d2e_rst", {63'd0, d2e_a}, 64'd1);
    check_value("mid_cnt_rst", {48'd0, cnt_a}, 64'd0);
    rst = 1'b1;
    tick;

    // Chain of dependent loads: five stalls, 2-bit counter saturates.
    pulse_reset;
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 5'd7, 2'b01);
      check_value("sat_stall", {63'd0, f2d_c}, 64'd0);
      tick;
      check_value("sat_go", {63'd0, f2d_c}, 64'd1);
      tick;
    end
    check_value("sat_cnt_c", {62'd0, cnt_c}, 64'd3);
    check_value("sat_cnt_a", {48'd0, cnt_a}, 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the decode-stage data-hazard/forwarding unit.
- Tracks the destination of every in-flight instruction across FWD_DEPTH downstream stages and forwards the youngest matching result to each of NUM_SRC decode operands.
- Stalls fetch/decode on load-use hazards, with a configurable load-data latency, and counts stall cycles.
- Sits between the instruction decoder and the decode-to-execute pipeline register.

Parameters:
- XLEN, 32, datapath width.
- REGISTER_SIZE, 5, register index width.
- NUM_SRC, 2, source operands checked per instruction.
- FWD_DEPTH, 2, downstream stages tracked (stage 1 = execute, stage 2 = memory access, ...).
- LOAD_LATENCY, 1, load data is unavailable in stages 1..LOAD_LATENCY and available from stage LOAD_LATENCY+1. Must be < FWD_DEPTH.
- CNT_WIDTH, 16, stall counter width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- dec_valid  input  1  decode holds a real instruction.
- dec_flush  input  1  squash the decode instruction this cycle.
- dec_dest  input  REGISTER_SIZE  decode destination register.
- dec_reg_write  input  1  decode instruction writes dec_dest.
- dec_is_load  input  1  decode instruction is a load.
- dec_src  input  NUM_SRC*REGISTER_SIZE  source register indices; slot i = bits [i*REGISTER_SIZE +: REGISTER_SIZE].
- dec_src_used  input  NUM_SRC  slot i is a real read.
- dec_operand  input  NUM_SRC*XLEN  register-file operand values.
- stage_data  input  FWD_DEPTH*XLEN  result value at stage k, slot k-1. The datapath supplies the ALU result, or DM read data for a load at stage >= LOAD_LATENCY+1.
- fwd_operand  output  NUM_SRC*XLEN  resolved operands to the pipeline register.
- fwd_sel  output  NUM_SRC*$clog2(FWD_DEPTH+1)  per slot: 0 = register file, k = stage k.
- f_to_d_enable_ff  output  1  fetch-to-decode flop enable (0 = stall).
- d_to_e_enable_ff  output  1  decode-to-execute flop enable (0 = stall).
- stall_count  output  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- State: entry[1..FWD_DEPTH], each {valid, dest, reg_write, is_load}, plus stall_count.
- Reset (rst low, asynchronous): all entries valid=0; stall_count=0. Combinational outputs follow their inputs against the empty tracker: enables=1, fwd_sel=0, fwd_operand=dec_operand.
- Match, slot i vs entry k: requires dec_valid, dec_src_used[i], src != 0, entry valid, reg_write=1, and dest == src.
  - Youngest match (lowest k) wins.
  - Register x0 is never forwarded or stalled on.
- Load-use: winning entry is a load with k <= LOAD_LATENCY -> hazard. A hazard on any slot sets stall.
- stall = hazard AND NOT dec_flush. When stall: f_to_d_enable_ff = d_to_e_enable_ff = 0.
- No hazard on slot i: fwd_sel = k of the winner (0 if no match); fwd_operand = stage_data[k] or dec_operand[i].
- Under stall, fwd_sel/fwd_operand still reflect the best non-stalling source; the value is don't-care because the pipeline register is held.
- Each rising edge (rst high), shift:
  - entry[k+1] <= entry[k].
  - entry[1] <= bubble (valid=0) if stall, dec_flush, or !dec_valid; otherwise {1, dec_dest, dec_reg_write, dec_is_load}.
- Stall semantics: decode holds, and bubbles drain the load forward one stage per cycle. With LOAD_LATENCY=L, a dependent instruction directly behind a load stalls exactly L cycles, then forwards from stage L+1.
- dec_flush together with a hazard: no stall, instruction squashed (bubble inserted).
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- Reset asserted mid-stall clears the tracker immediately; enables return to 1 combinationally.

Test Plan:
- ADD x5 then ADD x6,x5,x5 back to back (stage_data slot0=0x1234) -> both fwd_sel=1, fwd_operand=0x1234, no stall.
- LW x7 then ADD x8,x7,x1, LOAD_LATENCY=1 -> one stall cycle (enables=0, stall_count=1); next cycle fwd_sel[0]=2 with DM data 0xCAFE_F00D, fwd_sel[1]=0.
- Same as previous with LOAD_LATENCY=2, FWD_DEPTH=3 -> two stall cycles, then fwd_sel=3; stall_count=2.
- Write x0 then read x0, and a store (reg_write=0) writing a matching dest -> fwd_sel=0, no stall.
- ADD x9 (stage 2) and ADD x9 (stage 1) both in flight, then a reader of x9 -> fwd_sel=1 (youngest wins).
- Load-use hazard with dec_flush=1 -> enables=1, entry[1] becomes a bubble.
- Assert rst mid-stall -> enables=1 at once, stall_count=0.
- CNT_WIDTH=2 with 5 stall cycles -> stall_count saturates at 3.
